// File: rtl/distribute_1xn_multicast_buf_pkg.sv
// Shared definitions for the 1-to-N multicast distribution node and its lane FIFOs.
// Optional stall counter is enabled by defining DIST_STALL_CNT_EN.
package distribute_1xn_multicast_buf_pkg;

  localparam int                      DIST_STALL_CNT_W   = 16;
  localparam logic [DIST_STALL_CNT_W-1:0] DIST_STALL_CNT_MAX = 16'hFFFF;

  function automatic int distClog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  // A node whose command carries only the lane mask still forwards a 1-bit all-zero cmd.
  function automatic int distOutCmdWidth(input int inCmdWidth, input int numLanes);
    return (inCmdWidth == numLanes) ? 1 : (inCmdWidth - numLanes);
  endfunction

endpackage

// File: rtl/distribute_1xn_multicast_buf_lane_fifo.sv
// Single-lane first-word fall-through FIFO; read data is forced to zero while empty.
module dist_lane_fifo
  import distribute_1xn_multicast_buf_pkg::*;
#(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = distClog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (i_push) r_wrPtr <= r_wrPtr + 1'b1;
      if (i_pop)  r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr[AW-1:0]] <= i_data;
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign o_empty = (r_wrPtr == r_rdPtr);
  assign o_full  = (r_wrPtr[AW] != r_rdPtr[AW]) && (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign o_data  = o_empty ? '0 : r_mem[r_rdPtr[AW-1:0]];

endmodule

// File: rtl/distribute_1xn_multicast_buf.sv
// 1-to-N multicast node: lane mask in top cmd bits, per-lane FIFO with valid/ready.
// Define DIST_STALL_CNT_EN to add the saturating o_stall_cnt output.
module distribute_1xn_multicast_buf
  import distribute_1xn_multicast_buf_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int NUM_DATA_OUT     = 4,
  parameter int IN_COMMAND_WIDTH = 6,
  parameter int FIFO_DEPTH       = 4,
  localparam int OUT_COMMAND_WIDTH = distOutCmdWidth(IN_COMMAND_WIDTH, NUM_DATA_OUT)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  i_en,
  input  logic                                  i_valid,
  output logic                                  o_ready,
  input  logic [DATA_WIDTH-1:0]                 i_data_bus,
  input  logic [IN_COMMAND_WIDTH-1:0]           i_cmd,
  output logic [NUM_DATA_OUT-1:0]               o_valid,
  input  logic [NUM_DATA_OUT-1:0]               i_ready,
  output logic [NUM_DATA_OUT*DATA_WIDTH-1:0]    o_data_bus,
  output logic [NUM_DATA_OUT*OUT_COMMAND_WIDTH-1:0] o_cmd
`ifdef DIST_STALL_CNT_EN
  ,
  output logic [DIST_STALL_CNT_W-1:0]           o_stall_cnt
`endif
);

  localparam int LANE_W = DATA_WIDTH + OUT_COMMAND_WIDTH;

  logic [NUM_DATA_OUT-1:0]      w_mask;
  logic [OUT_COMMAND_WIDTH-1:0] w_nextCmd;
  logic [NUM_DATA_OUT-1:0]      w_laneFull;
  logic [NUM_DATA_OUT-1:0]      w_laneEmpty;
  logic [NUM_DATA_OUT-1:0]      w_lanePush;
  logic [NUM_DATA_OUT-1:0]      w_lanePop;
  logic [LANE_W-1:0]            w_laneData [NUM_DATA_OUT];
  logic                         w_accept;

  assign w_mask = i_cmd[IN_COMMAND_WIDTH-1 -: NUM_DATA_OUT];

  if (IN_COMMAND_WIDTH == NUM_DATA_OUT) begin : g_noNextCmd
    assign w_nextCmd = '0;
  end else begin : g_nextCmd
    assign w_nextCmd = i_cmd[OUT_COMMAND_WIDTH-1:0];
  end

  // Fullness is registered, so ready never combinationally depends on i_ready.
  assign o_ready  = i_en & ~|(w_mask & w_laneFull);
  assign w_accept = i_valid & o_ready;

  for (genvar k = 0; k < NUM_DATA_OUT; k++) begin : g_lane
    assign w_lanePush[k] = w_accept & w_mask[k];
    assign w_lanePop[k]  = ~w_laneEmpty[k] & i_ready[k] & i_en;
    assign o_valid[k]    = ~w_laneEmpty[k];

    dist_lane_fifo #(
      .WIDTH (LANE_W),
      .DEPTH (FIFO_DEPTH)
    ) u_laneFifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_lanePush[k]),
      .i_pop   (w_lanePop[k]),
      .i_data  ({i_data_bus, w_nextCmd}),
      .o_data  (w_laneData[k]),
      .o_full  (w_laneFull[k]),
      .o_empty (w_laneEmpty[k])
    );

    assign o_data_bus[k*DATA_WIDTH +: DATA_WIDTH]           = w_laneData[k][LANE_W-1 -: DATA_WIDTH];
    assign o_cmd[k*OUT_COMMAND_WIDTH +: OUT_COMMAND_WIDTH]  = w_laneData[k][OUT_COMMAND_WIDTH-1:0];
  end

`ifdef DIST_STALL_CNT_EN
  logic [DIST_STALL_CNT_W-1:0] r_stallCnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_stallCnt <= '0;
    end else if (i_valid && i_en && !o_ready && (r_stallCnt != DIST_STALL_CNT_MAX)) begin
      r_stallCnt <= r_stallCnt + 1'b1;
    end
  end

  assign o_stall_cnt = r_stallCnt;
`endif

endmodule

// File: tb/tb_distribute_1xn_multicast_buf.sv
// Randomized self-checking bench for distribute_1xn_multicast_buf against a queue-based lane model.
// Covers DIST_STALL_CNT_EN checks when that macro is defined.
module tb_distribute_1xn_multicast_buf;

  localparam int DW    = 32;
  localparam int NL    = 4;
  localparam int ICW   = 6;
  localparam int OCW   = 2;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              i_en;
  logic              i_valid;
  logic              o_ready;
  logic [DW-1:0]     i_data_bus;
  logic [ICW-1:0]    i_cmd;
  logic [NL-1:0]     o_valid;
  logic [NL-1:0]     i_ready;
  logic [NL*DW-1:0]  o_data_bus;
  logic [NL*OCW-1:0] o_cmd;
`ifdef DIST_STALL_CNT_EN
  logic [15:0]       o_stall_cnt;
`endif

  always #5 clk = ~clk;

  distribute_1xn_multicast_buf #(
    .DATA_WIDTH       (DW),
    .NUM_DATA_OUT     (NL),
    .IN_COMMAND_WIDTH (ICW),
    .FIFO_DEPTH       (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_en       (i_en),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_data_bus (i_data_bus),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_data_bus (o_data_bus),
    .o_cmd      (o_cmd)
`ifdef DIST_STALL_CNT_EN
    ,
    .o_stall_cnt(o_stall_cnt)
`endif
  );

  // Each lane is a plain queue of {data, forwarded cmd} words.
  logic [DW+OCW-1:0] laneQ [NL][$];
  int  checks     = 0;
  int  failures   = 0;
  bit  modelValid = 1'b0;
  int  stallModel = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic en, input logic valid,
                               input logic [DW-1:0] data, input logic [ICW-1:0] cmd,
                               input logic [NL-1:0] rdy);
    logic              expReady;
    logic [DW+OCW-1:0] front;
    rst_n      = rst;
    i_en       = en;
    i_valid    = valid;
    i_data_bus = data;
    i_cmd      = cmd;
    i_ready    = rdy;

    expReady = en;
    for (int k = 0; k < NL; k++)
      if (cmd[ICW-NL+k] && laneQ[k].size() >= DEPTH) expReady = 1'b0;

    @(negedge clk);
    if (modelValid) begin
      checkOutput("o_ready", 64'(o_ready), 64'(expReady));
      for (int k = 0; k < NL; k++) begin
        front = (laneQ[k].size() > 0) ? laneQ[k][0] : '0;
        checkOutput($sformatf("o_valid[%0d]", k), 64'(o_valid[k]), 64'(laneQ[k].size() > 0));
        checkOutput($sformatf("data[%0d]", k), 64'(o_data_bus[k*DW +: DW]), 64'(front[DW+OCW-1:OCW]));
        checkOutput($sformatf("cmd[%0d]", k), 64'(o_cmd[k*OCW +: OCW]), 64'(front[OCW-1:0]));
      end
`ifdef DIST_STALL_CNT_EN
      checkOutput("stall_cnt", 64'(o_stall_cnt), 64'(stallModel));
`endif
    end

    @(posedge clk);
    if (!rst) begin
      for (int k = 0; k < NL; k++) laneQ[k].delete();
      stallModel = 0;
      modelValid = 1'b1;
    end else if (modelValid) begin
      for (int k = 0; k < NL; k++)
        if (en && rdy[k] && laneQ[k].size() > 0) void'(laneQ[k].pop_front());
      if (valid && expReady) begin
        for (int k = 0; k < NL; k++)
          if (cmd[ICW-NL+k]) laneQ[k].push_back({data, cmd[OCW-1:0]});
      end
      if (valid && en && !expReady && stallModel < 65535) stallModel++;
    end
    #1;
  endtask

  initial begin
    // Reset with valid asserted must leave every lane empty.
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h12345678, 6'b111111, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h12345678, 6'b111111, 4'hF);
    checkOutput("t1_valid", 64'(o_valid), 64'h0);
    checkOutput("t1_data", 64'(o_data_bus[63:0]), 64'h0);

    // Unicast to lane 2.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hAAAAAAAA, 6'b010010, 4'hF);
    checkOutput("t2_valid", 64'(o_valid), 64'b0100);
    checkOutput("t2_data2", 64'(o_data_bus[2*DW +: DW]), 64'hAAAAAAAA);
    checkOutput("t2_cmd2", 64'(o_cmd[2*OCW +: OCW]), 64'b10);
    checkOutput("t2_data0", 64'(o_data_bus[DW-1:0]), 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 6'b0, 4'hF);

    // Multicast to lanes 0,1,3 with lane 1 stalled.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hBBBB0000 + 32'(i), 6'b101101, 4'b1101);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 1'b1, 1'b1, 32'hBBBB0004, 6'b101101, 4'b1101);
    checkOutput("t3_blocked", 64'(o_ready), 64'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hBBBB0004, 6'b101101, 4'hF);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hBBBB0004, 6'b101101, 4'hF);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 6'b0, 4'hF);
    checkOutput("t3_drained", 64'(o_valid), 64'h0);

    // Zero mask is accepted and dropped.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hCAFEF00D, 6'b000011, 4'hF);
    checkOutput("t4_ready", 64'(o_ready), 64'h1);
    checkOutput("t4_valid", 64'(o_valid), 64'h0);

    // Disable with data pending freezes pops.
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hD0000001, 6'b111101, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hD0000002, 6'b111110, 4'h0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b1, 32'hD0000003, 6'b111111, 4'hF);
    checkOutput("t5_held", 64'(o_valid), 64'hF);
    checkOutput("t5_data1", 64'(o_data_bus[DW +: DW]), 64'hD0000001);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 6'b0, 4'hF);

    // Seven blocked cycles on a full lane 0.
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 6'b0, 4'h0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b1, 32'hE0000000 + 32'(i), 6'b000101, 4'h0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b1, 1'b1, 32'hEEEEEEEE, 6'b000101, 4'h0);
`ifdef DIST_STALL_CNT_EN
    checkOutput("t6_stall7", 64'(o_stall_cnt), 64'd7);
`endif
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0, 6'b000101, 4'h0);
`ifdef DIST_STALL_CNT_EN
    checkOutput("t6_stall0", 64'(o_stall_cnt), 64'd0);
`endif
    checkOutput("t6_empty", 64'(o_valid), 64'h0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++)
      applyStimulus(($urandom_range(0, 59) != 0), ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 3) != 0), $urandom, 6'($urandom), 4'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
